tape_reader: RTL and testbench
==============================

// Module: tape_reader
// PURPOSE
//  Input-side counterpart of the printer: models the EDSAC 5-hole tape reader serving the I (input) order.
//  On a decoded I order it fetches one tape character and holds main control via stop_one_c.
//  After a mechanical settle delay it drives one 36-digit serial store word (character in digits 0-4,
//  zeros elsewhere) on rdr_bit/rdr_gate, then pulses rdr_done.
// PARAMETERS
//  SETTLE_CYCLES  40  clocks of reader mechanical delay after character capture (>=1)
//  CHAR_W          5  tape character width
//  WORD_DIGITS    36  digit times per minor cycle (serial word length)
// PORTS
//  clk          in   1       digit clock (one clock = one digit time)
//  rst_n        in   1       asynchronous active-low reset
//  op_i         in   1       decoded I order, level, held by control
//  d0           in   1       minor-cycle strobe; high in cycle t => digit 0 occupies cycle t+1
//  tape_valid   in   1       tape source presents a character
//  tape_data    in   CHAR_W  character, bit0 = digit 0
//  tape_eot     in   1       tape source exhausted
//  tape_ready   out  1       reader accepts a character
//  rdr_busy     out  1       reader not IDLE
//  stop_one_c   out  1       hold main control
//  rdr_gate     out  1       store write gate, high for all WORD_DIGITS digits of the write
//  rdr_bit      out  1       serial write data, LSB first
//  rdr_done     out  1       one-cycle completion pulse
//  tape_fault   out  1       sticky end-of-tape fault
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output; state IDLE; counters 0; armed=1.
//  - States: IDLE, REQ, SETTLE, ALIGN, SHIFT, DONE, FAULT.
//  - IDLE: op_i=1 && armed -> REQ, armed<=0. armed<=1 whenever op_i=0 (no double read on a held op_i).
//  - op_i is sampled only in IDLE; deassertion mid-operation is ignored and the operation completes.
//  - REQ: tape_ready=1. Transfer = tape_valid && tape_ready; capture tape_data -> SETTLE with cnt=0.
//    tape_eot=1 with tape_valid=0 -> FAULT. tape_valid and tape_eot both high: the transfer wins.
//  - SETTLE: cnt counts 0..SETTLE_CYCLES-1; at terminal count -> ALIGN.
//  - ALIGN: first d0 seen while in ALIGN -> SHIFT, digit=0. A d0 in the SETTLE terminal cycle is not used.
//  - SHIFT: WORD_DIGITS cycles. rdr_gate=1; rdr_bit = char[digit] for digit<CHAR_W, else 0.
//    digit wraps at WORD_DIGITS-1 -> DONE. d0 pulses during SHIFT are ignored.
//  - DONE: rdr_done=1 for exactly one cycle -> IDLE.
//  - stop_one_c = rdr_busy = 1 in every state except IDLE. The REQ->SHIFT latency is SETTLE_CYCLES plus d0 wait.
//  - FAULT: tape_fault=1, stop_one_c=1, rdr_busy=1. Exit only by rst_n.
//  - Reset mid-operation: immediate return to IDLE, gate/bit drop the same instant, captured char discarded.
// CONFIGURATION
//  TAPE_BLANK_SKIP_EN defined: a captured character of 0 (blank/leader) is discarded;
//    REQ -> REQ (tape_ready stays 1), no SETTLE, no write, no rdr_done.
//  TAPE_BLANK_SKIP_EN undefined: a 0 character is treated like any other (all-zero word written).
// STRUCTURE
//  Shared package edsac_io_pkg: rdr_state_t enum, CHAR_W and WORD_DIGITS constants (shared with printer).
//  Single module, no sub-modules; the serialiser is an index mux on the digit counter.
// TESTING
//  1 op_i=1, tape 5'b10011, SETTLE_CYCLES=4 -> tape_ready 1 cycle. After d0: rdr_bit 1,1,0,0,1 then
//    31 zeros. rdr_gate high 36 cycles, then rdr_done pulse; stop_one_c low next cycle.
//  2 op_i held high across DONE -> no second tape_ready until op_i low >=1 cycle then high again.
//  3 REQ with tape_eot=1, tape_valid=0 -> tape_fault=1 and stop_one_c=1 persist; rst_n low -> all 0.
//  4 rst_n asserted at digit 2 of SHIFT -> rdr_gate/rdr_bit 0 immediately. Next op_i starts a clean REQ.
//  5 d0 coincident with SETTLE terminal count -> SHIFT starts only after the following d0.
//  6 TAPE_BLANK_SKIP_EN: tape 0,0,5'b00001 -> three transfers, one 36-digit write of digit0=1, one rdr_done.
//    Without the macro: first 0 gives an all-zero write and rdr_done.

Source files
------------

// File: rtl/edsac_io_pkg.sv
// rtl/edsac_io_pkg.sv - EDSAC I/O shared types and word geometry (reader and printer)
package edsac_io_pkg;

  localparam int CHAR_W      = 5;
  localparam int WORD_DIGITS = 36;

  typedef enum logic [2:0] {
    RDR_IDLE,
    RDR_REQ,
    RDR_SETTLE,
    RDR_ALIGN,
    RDR_SHIFT,
    RDR_DONE,
    RDR_FAULT
  } rdr_state_t;

endpackage

// File: rtl/tape_reader.sv
// rtl/tape_reader.sv - EDSAC 5-hole tape reader serving the I order
// Optional TAPE_BLANK_SKIP_EN: blank (zero) characters are consumed without a store write.
module tape_reader
  import edsac_io_pkg::*;
#(
  parameter int SETTLE_CYCLES = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_i,
  input  logic              d0,
  input  logic              tape_valid,
  input  logic [CHAR_W-1:0] tape_data,
  input  logic              tape_eot,
  output logic              tape_ready,
  output logic              rdr_busy,
  output logic              stop_one_c,
  output logic              rdr_gate,
  output logic              rdr_bit,
  output logic              rdr_done,
  output logic              tape_fault
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DIG_W = $clog2(WORD_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(WORD_DIGITS - 1);

  rdr_state_t        state_q, state_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              gate_q, gate_d;
  logic              bit_q, bit_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              blank;

  always_comb begin
    state_d = state_q;
    armed_d = armed_q | ~op_i;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    char_d  = char_q;
    blank   = 1'b0;
`ifdef TAPE_BLANK_SKIP_EN
    blank   = (tape_data == '0);
`endif
    unique case (state_q)
      RDR_IDLE: begin
        if (op_i && armed_q) begin
          state_d = RDR_REQ;
          armed_d = 1'b0;
        end
      end
      RDR_REQ: begin
        // A present character beats end-of-tape; blanks keep the request open.
        if (tape_valid) begin
          if (!blank) begin
            char_d  = tape_data;
            cnt_d   = '0;
            state_d = RDR_SETTLE;
          end
        end else if (tape_eot) begin
          state_d = RDR_FAULT;
        end
      end
      RDR_SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = RDR_ALIGN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      RDR_ALIGN: begin
        if (d0) begin
          state_d = RDR_SHIFT;
          digit_d = '0;
        end
      end
      RDR_SHIFT: begin
        if (digit_q == DIG_LAST) begin
          state_d = RDR_DONE;
          digit_d = '0;
        end else begin
          digit_d = digit_q + 1'b1;
        end
      end
      RDR_DONE:  state_d = RDR_IDLE;
      RDR_FAULT: state_d = RDR_FAULT;
      default:   state_d = RDR_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each flop lines up with its state.
  always_comb begin
    ready_d = (state_d == RDR_REQ);
    busy_d  = (state_d != RDR_IDLE);
    gate_d  = (state_d == RDR_SHIFT);
    done_d  = (state_d == RDR_DONE);
    fault_d = (state_d == RDR_FAULT);
    bit_d   = 1'b0;
    for (int i = 0; i < CHAR_W; i++) begin
      if (gate_d && (digit_d == DIG_W'(i))) bit_d = char_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RDR_IDLE;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      digit_q <= '0;
      char_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      gate_q  <= 1'b0;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      char_q  <= char_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      gate_q  <= gate_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign tape_ready = ready_q;
  assign rdr_busy   = busy_q;
  assign stop_one_c = busy_q;
  assign rdr_gate   = gate_q;
  assign rdr_bit    = bit_q;
  assign rdr_done   = done_q;
  assign tape_fault = fault_q;

endmodule

// File: tb/tb_tape_reader.sv
// tb/tb_tape_reader.sv - self-checking bench for tape_reader with a per-cycle reference model
module tb_tape_reader;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_i = 1'b0;
  logic       d0 = 1'b0;
  logic       tape_valid = 1'b0;
  logic [4:0] tape_data = '0;
  logic       tape_eot = 1'b0;
  logic       tape_ready, rdr_busy, stop_one_c, rdr_gate, rdr_bit, rdr_done, tape_fault;

  int checks = 0;
  int errors = 0;

  tape_reader #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .d0(d0),
    .tape_valid(tape_valid), .tape_data(tape_data), .tape_eot(tape_eot),
    .tape_ready(tape_ready), .rdr_busy(rdr_busy), .stop_one_c(stop_one_c),
    .rdr_gate(rdr_gate), .rdr_bit(rdr_bit), .rdr_done(rdr_done), .tape_fault(tape_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle,1 request,2 settle,3 align,4 shift,5 done,6 fault
  int          m_ph = 0;
  bit          m_armed = 1'b1;
  int          m_left = 0;
  int          m_pos = 0;
  logic [35:0] m_word = '0;

  int          ready_cyc = 0, xfer_cnt = 0, gate_cnt = 0, done_cnt = 0;
  logic [35:0] cap_word = '0;

  task automatic clr_stats();
    ready_cyc = 0; xfer_cnt = 0; gate_cnt = 0; done_cnt = 0; cap_word = '0;
  endtask

  always @(negedge clk) begin
    logic [6:0] expv, actv;
    bit a_prev, blank;
    actv = {tape_ready, rdr_busy, stop_one_c, rdr_gate, rdr_bit, rdr_done, tape_fault};
    if (!rst_n) begin
      m_ph = 0; m_armed = 1'b1;
      chk("outputs_in_reset", 64'(actv), 64'(7'b0));
    end else begin
      expv = {m_ph == 1, m_ph != 0, m_ph != 0, m_ph == 4,
              (m_ph == 4) ? m_word[m_pos] : 1'b0, m_ph == 5, m_ph == 6};
      chk("outputs", 64'(actv), 64'(expv));
      if (tape_ready) ready_cyc++;
      if (tape_ready && tape_valid) xfer_cnt++;
      if (rdr_done) done_cnt++;
      if (rdr_gate) begin
        if (gate_cnt < 36) cap_word[gate_cnt] = rdr_bit;
        gate_cnt++;
      end
      a_prev = m_armed;
      if (!op_i) m_armed = 1'b1;
      blank = 1'b0;
`ifdef TAPE_BLANK_SKIP_EN
      blank = (tape_data == 5'd0);
`endif
      case (m_ph)
        0: if (op_i && a_prev) begin m_ph = 1; m_armed = 1'b0; end
        1: if (tape_valid) begin
             if (!blank) begin m_word = {31'd0, tape_data}; m_left = SETTLE; m_ph = 2; end
           end else if (tape_eot) m_ph = 6;
        2: begin m_left--; if (m_left == 0) m_ph = 3; end
        3: if (d0) begin m_ph = 4; m_pos = 0; end
        4: if (m_pos == 35) m_ph = 5; else m_pos++;
        5: m_ph = 0;
        default: m_ph = m_ph;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [4:0] ch);
    bit took = 1'b0;
    tape_valid = 1'b1; tape_data = ch;
    for (int i = 0; i < 50 && !took; i++) begin
      @(negedge clk);
      if (tape_ready) begin
        tick();
        took = 1'b1;
      end
    end
    tape_valid = 1'b0;
    chk("feed_accepted", 64'(took), 64'(1));
  endtask

  task automatic settle_and_shift();
    repeat (SETTLE) tick();
    d0 = 1'b1; tick(); d0 = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rdr_done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'(1));
    tick();
  endtask

  task automatic start_op();
    op_i = 1'b0; tick(); op_i = 1'b1; clr_stats();
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_busy", 64'(rdr_busy), 64'(0));
    rst_n = 1'b1;
    tick();

    // 1: basic read of 10011
    start_op();
    feed(5'b10011);
    settle_and_shift();
    wait_done();
    chk("t1_stop_after_done", 64'(stop_one_c), 64'(0));
    chk("t1_word", 64'(cap_word), 64'h13);
    chk("t1_gate_cycles", 64'(gate_cnt), 64'(36));
    chk("t1_ready_cycles", 64'(ready_cyc), 64'(1));
    chk("t1_done_count", 64'(done_cnt), 64'(1));

    // 2: held op_i does not re-trigger
    repeat (10) tick();
    chk("t2_no_rerequest", 64'(ready_cyc), 64'(1));
    chk("t2_idle", 64'(rdr_busy), 64'(0));
    start_op();
    feed(5'b00110);
    settle_and_shift();
    wait_done();
    chk("t2_word", 64'(cap_word), 64'h6);

    // 5: d0 on settle terminal count is ignored
    start_op();
    feed(5'b01010);
    repeat (SETTLE - 1) tick();
    d0 = 1'b1; tick(); d0 = 1'b0;
    chk("t5_no_shift_yet", 64'({rdr_gate, rdr_busy}), 64'(2'b01));
    repeat (2) tick();
    chk("t5_still_waiting", 64'(rdr_gate), 64'(0));
    d0 = 1'b1; tick(); d0 = 1'b0;
    chk("t5_shift_started", 64'({rdr_gate, rdr_bit}), 64'(2'b10));
    wait_done();
    chk("t5_word", 64'(cap_word), 64'hA);

    // 4: reset at digit 2 of shift
    start_op();
    feed(5'b11111);
    settle_and_shift();
    tick(); tick();
    chk("t4_digit2_live", 64'({rdr_gate, rdr_bit}), 64'(2'b11));
    #1 rst_n = 1'b0;
    #1 chk("t4_drop_now", 64'({rdr_gate, rdr_bit, rdr_busy}), 64'(3'b000));
    op_i = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); op_i = 1'b1; clr_stats();
    tick();
    chk("t4_clean_req", 64'({tape_ready, rdr_gate}), 64'(2'b10));
    feed(5'b00001);
    settle_and_shift();
    wait_done();
    chk("t4_word", 64'(cap_word), 64'h1);
    chk("t4_gate_cycles", 64'(gate_cnt), 64'(36));

    // 3: end of tape fault
    op_i = 1'b0; tape_eot = 1'b1; tick();
    op_i = 1'b1;
    repeat (3) tick();
    chk("t3_fault", 64'({tape_fault, stop_one_c, tape_ready}), 64'(3'b110));
    repeat (5) tick();
    tape_eot = 1'b0; op_i = 1'b0;
    tick();
    chk("t3_fault_sticky", 64'({tape_fault, stop_one_c, rdr_busy}), 64'(3'b111));
    rst_n = 1'b0;
    #1 chk("t3_reset_clears",
           64'({tape_ready, rdr_busy, stop_one_c, rdr_gate, rdr_bit, rdr_done, tape_fault}),
           64'(7'b0));
    tick(); rst_n = 1'b1; tick();

    // 6: blank characters
    start_op();
`ifdef TAPE_BLANK_SKIP_EN
    feed(5'd0); feed(5'd0); feed(5'b00001);
    settle_and_shift();
    wait_done();
    chk("t6_transfers", 64'(xfer_cnt), 64'(3));
    chk("t6_word", 64'(cap_word), 64'h1);
`else
    feed(5'd0);
    settle_and_shift();
    wait_done();
    chk("t6_transfers", 64'(xfer_cnt), 64'(1));
    chk("t6_word", 64'(cap_word), 64'h0);
`endif
    chk("t6_gate_cycles", 64'(gate_cnt), 64'(36));
    chk("t6_done_count", 64'(done_cnt), 64'(1));

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
